uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// 8N1-style UART transmitter and receiver with a shared free-running 16x oversample tick.
// Define UART_PARITY_EN to add one parity bit per frame (sense set by PARITY_ODD).
module uart_core #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
`endif

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_bad_params
    $error("uart_core: illegal parameter set");
  end

  // ---------------------------------------------------------------- tick
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  tx_state_e            tx_state_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic [3:0]           tx_tick_q;
  logic [2:0]           tx_bit_q;
  logic                 tx_q;
  logic                 tx_ready_q;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tx_state_q != TX_IDLE && tick) tx_tick_q <= tx_tick_q + 4'd1;
      case (tx_state_q)
        TX_IDLE: begin
          // A latched word waits with tx_ready low until the next tick opens START.
          if (tx_ready_q) begin
            if (tx_valid) begin
              tx_shift_q <= tx_data;
              tx_ready_q <= 1'b0;
`ifdef UART_PARITY_EN
              tx_par_q   <= (^tx_data) ^ PAR_SENSE;
`endif
            end
          end else if (tick) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_tick_q  <= '0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
              tx_state_q <= TX_PARITY;
              tx_q       <= tx_par_q;
`else
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
`endif
              tx_bit_q   <= '0;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bit_q == LAST_STOP) begin
              tx_state_q <= TX_IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  logic rx_s1_q, rx_s2_q;
  logic rx_ok1_q, rx_ok2_q;

  // Synchroniser idles high; rx_ok2_q marks when rx_s2_q reflects the real line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_ok1_q <= 1'b0;
      rx_ok2_q <= 1'b0;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      rx_ok1_q <= 1'b1;
      rx_ok2_q <= rx_ok1_q;
    end
  end

  rx_state_e            rx_state_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic [3:0]           rx_tick_q;
  logic [2:0]           rx_bit_q;
  logic                 rx_armed_q;
  logic                 rx_valid_q;
  logic                 rx_ferr_q;
  logic                 rx_mid;
  logic                 rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 rx_par_q;
  logic                 rx_perr_q;
`endif

  assign rx_mid     = tick && (rx_tick_q == 4'd7);
  assign rx_bit_end = tick && (rx_tick_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_armed_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      if (rx_state_q != RX_IDLE && tick) rx_tick_q <= rx_tick_q + 4'd1;
      case (rx_state_q)
        RX_IDLE: begin
          // Only a low that follows a genuinely observed high starts a frame.
          rx_armed_q <= rx_ok2_q & rx_s2_q;
          if (rx_armed_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= '0;
            rx_armed_q <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_mid && rx_s2_q) begin
            rx_state_q <= RX_IDLE;
          end else if (rx_bit_end) begin
            rx_state_q <= RX_DATA;
            rx_bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_mid) rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_end) begin
            if (rx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PARITY;
`else
              rx_state_q <= RX_STOP;
`endif
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_mid)     rx_par_q   <= rx_s2_q;
          if (rx_bit_end) rx_state_q <= RX_STOP;
        end
`endif
        RX_STOP: begin
          if (rx_mid) begin
            rx_state_q <= RX_IDLE;
            rx_data_q  <= rx_shift_q;
            rx_ferr_q  <= ~rx_s2_q;
            rx_valid_q <= 1'b1;
`ifdef UART_PARITY_EN
            rx_perr_q  <= ((^rx_shift_q) ^ rx_par_q) != PAR_SENSE;
`endif
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected frames/words, monitors pop and compare.
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_core;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int DB       = 8;
  localparam int SB       = 1;
  localparam int PODD     = 0;
  localparam int BIT      = CLK_FREQ / BAUD;   // 160 clocks per bit
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_parity_err;

  uart_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(PODD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } tx_frame_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_exp_t;

  tx_frame_t  tx_exp_q[$];
  rx_exp_t    rx_exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rx_pulses = 0;
  bit         tx_mon_busy = 1'b0;
  logic [7:0] last_rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Parity bit that makes the count of ones even (or odd when PODD=1).
  function automatic logic par_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ (PODD == 1);
  endfunction

  function automatic tx_frame_t build_frame(input logic [7:0] d);
    tx_frame_t f;
    f.bits = '1;
    f.n    = 0;
    f.bits[f.n] = 1'b0;
    f.n++;
    for (int i = 0; i < DB; i++) begin
      f.bits[f.n] = d[i];
      f.n++;
    end
    if (PAR_EN) begin
      f.bits[f.n] = par_of(d);
      f.n++;
    end
    for (int s = 0; s < SB; s++) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  task automatic send_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    if (tx_ready === 1'b1) begin
      tx_data  = d;
      tx_valid = 1'b1;
      tx_exp_q.push_back(build_frame(d));
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_drop", tx_ready, 0);
    end
  endtask

  // Drives one frame onto rx; par_ok=0 inverts the parity bit, stop_lvl=0 forces a frame error.
  task automatic drive_rx(input logic [7:0] d, input logic par_ok, input logic stop_lvl,
                          input bit push);
    rx_exp_t e;
    if (push) begin
      e.data = d;
      e.ferr = ~stop_lvl;
      e.perr = PAR_EN & ~par_ok;
      rx_exp_q.push_back(e);
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = par_of(d) ^ ~par_ok;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop_lvl;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || tx_mon_busy) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_exp_q.size() + rx_exp_q.size() + int'(tx_mon_busy), 0);
  endtask

  // TX monitor: checks every cycle of each frame against the expected bit sequence.
  initial begin : tx_mon
    tx_frame_t f;
    int        bad, bad_rdy;
    bit        abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        check("tx_sb_nonempty", tx_exp_q.size() != 0, 1);
        if (tx_exp_q.size() != 0) begin
          f           = tx_exp_q.pop_front();
          tx_mon_busy = 1'b1;
          abort       = 1'b0;
          for (int b = 0; b < f.n && !abort; b++) begin
            bad     = 0;
            bad_rdy = 0;
            for (int c = 0; c < BIT && !abort; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_n !== 1'b1) abort = 1'b1;
              else begin
                if (tx !== f.bits[b]) bad++;
                if (tx_ready !== 1'b0) bad_rdy++;
              end
            end
            if (!abort) begin
              check($sformatf("tx_bit%0d_cycles_wrong", b), bad, 0);
              check($sformatf("tx_bit%0d_ready_high", b), bad_rdy, 0);
            end
          end
          if (!abort) begin
            @(negedge clk);
            check("tx_ready_after_frame", tx_ready, 1);
          end
          tx_mon_busy = 1'b0;
        end else begin
          for (int k = 0; k < 20000 && tx === 1'b0; k++) @(negedge clk);
        end
      end
    end
  end

  // RX monitor: every rx_valid must match the oldest expected word and last one cycle.
  initial begin : rx_mon
    rx_exp_t e;
    bit      prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rx_valid === 1'b1) begin
        check("rx_valid_pulse_width", prev_v, 0);
        check("rx_sb_nonempty", rx_exp_q.size() != 0, 1);
        if (rx_exp_q.size() != 0) begin
          e = rx_exp_q.pop_front();
          check("rx_data", rx_data, e.data);
          check("rx_frame_err", rx_frame_err, e.ferr);
          check("rx_parity_err", rx_parity_err, e.perr);
          last_rx = e.data;
        end
        rx_pulses++;
      end
      prev_v = (rx_valid === 1'b1);
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pulses0;
    bit bad_stop, par_ok;

    rst_n    = 1'b0;
    rx       = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (5) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_frame_err", rx_frame_err, 0);
    check("reset_rx_parity_err", rx_parity_err, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_tx(8'hA5);
    wait_drain("drain_tx_a5");

    drive_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_rx_3c");

    drive_rx(8'h55, 1'b1, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    drive_rx(8'h0F, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_rx_55_0f");

    pulses0 = rx_pulses;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_rx_valid_count", rx_pulses - pulses0, 0);
    check("rx_data_hold", rx_data, last_rx);
    check("rx_frame_err_hold", rx_frame_err, 0);

`ifdef UART_PARITY_EN
    drive_rx(8'h07, 1'b0, 1'b1, 1'b1);
    send_tx(8'h07);
    wait_drain("drain_parity_07");
`endif

    fork
      begin : tx_rand
        for (int i = 0; i < 6; i++) begin
          send_tx(8'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(50, 800)) @(negedge clk);
            tx_data  = 8'($urandom);
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
          end
        end
      end
      begin : rx_rand
        for (int i = 0; i < 6; i++) begin
          bad_stop = ($urandom_range(0, 4) == 0);
          par_ok   = ($urandom_range(0, 3) != 0);
          drive_rx(8'($urandom), par_ok, ~bad_stop, 1'b1);
          if (bad_stop) repeat (BIT) @(negedge clk);
          else if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 300)) @(negedge clk);
        end
      end
    join
    wait_drain("drain_random");

    pulses0 = rx_pulses;
    fork
      send_tx(8'hF0);
      begin
        @(negedge clk);
        rx = 1'b0;
      end
    join
    repeat (4 * BIT) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_tx", tx, 1);
    check("midframe_reset_tx_ready", tx_ready, 1);
    check("midframe_reset_rx_valid", rx_valid, 0);
    check("midframe_reset_rx_data", rx_data, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (11 * BIT) @(negedge clk);
    check("no_frame_from_low_line", rx_pulses - pulses0, 0);
    check("tx_ready_after_reset", tx_ready, 1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    fork
      send_tx(8'h81);
      drive_rx(8'h81, 1'b1, 1'b1, 1'b1);
    join
    wait_drain("drain_after_reset_81");
    check("rx_81_received", last_rx, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
